// File: rtl/jt49_bus_pkg.sv
// Shared definitions for the jt49 bus-control responder.
// Holds bus-mode codes, the FSM state type, named register indices and the
// per-register readback mask table used by jt49_bus and jt49_bus_regs.
package jt49_bus_pkg;

    // Decoded {bdir,bc1} bus modes
    localparam logic [1:0] MODE_IDLE  = 2'b00;
    localparam logic [1:0] MODE_READ  = 2'b01;
    localparam logic [1:0] MODE_WRITE = 2'b10;
    localparam logic [1:0] MODE_LATCH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_LATCH = 2'b11
    } state_t;

    localparam logic [3:0] REG_MIXER     = 4'd7;
    localparam logic [3:0] REG_ENV_SHAPE = 4'd13;
    localparam logic [3:0] REG_IOA       = 4'd14;
    localparam logic [3:0] REG_IOB       = 4'd15;

    // Readback masks, index 15 in the leftmost slot down to index 0.
    // Coarse-period/shape registers expose 4 bits, noise/amplitude 5 bits.
    localparam logic [15:0][7:0] RD_MASK = {
        8'hFF, 8'hFF, 8'h0F, 8'hFF,   // R15 R14 R13 R12
        8'hFF, 8'h1F, 8'h1F, 8'h1F,   // R11 R10 R9  R8
        8'hFF, 8'h1F, 8'h0F, 8'hFF,   // R7  R6  R5  R4
        8'h0F, 8'hFF, 8'h0F, 8'hFF    // R3  R2  R1  R0
    };

    function automatic logic [7:0] rd_mask(input logic [3:0] idx);
        return RD_MASK[idx];
    endfunction

endpackage

// File: rtl/jt49_bus_regs.sv
// Purpose : 16x8 PSG register file, decoded field outputs and masked read mux.
// Latency : write visible on fields the edge after i_we; o_rdat is combinational.
// Backpressure: none; a write strobe is always accepted.
// Ports   : i_clk/i_rst, write port (i_we/i_waddr/i_wdat), read address i_raddr,
//           IO port inputs i_port_a_in/i_port_b_in, field outputs o_*, o_rdat.
// Optional: JT49_IOPORT_EN routes synchronised IO inputs onto R14/R15 reads
//           while the matching mixer bit selects input mode.
module jt49_bus_regs
    import jt49_bus_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we,
    input  logic [3:0]  i_waddr,
    input  logic [7:0]  i_wdat,
    input  logic [3:0]  i_raddr,
    input  logic [7:0]  i_port_a_in,
    input  logic [7:0]  i_port_b_in,
    output logic [7:0]  o_rdat,
    output logic [11:0] o_per_a,
    output logic [11:0] o_per_b,
    output logic [11:0] o_per_c,
    output logic [4:0]  o_per_noise,
    output logic [7:0]  o_mixer,
    output logic [4:0]  o_amp_a,
    output logic [4:0]  o_amp_b,
    output logic [4:0]  o_amp_c,
    output logic [15:0] o_per_env,
    output logic [3:0]  o_env_shape,
    output logic [7:0]  o_port_a_out,
    output logic [7:0]  o_port_b_out
);

    logic [15:0][7:0] r_mem;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_per_a      = {r_mem[1][3:0], r_mem[0]};
    assign o_per_b      = {r_mem[3][3:0], r_mem[2]};
    assign o_per_c      = {r_mem[5][3:0], r_mem[4]};
    assign o_per_noise  = r_mem[6][4:0];
    assign o_mixer      = r_mem[REG_MIXER];
    assign o_amp_a      = r_mem[8][4:0];
    assign o_amp_b      = r_mem[9][4:0];
    assign o_amp_c      = r_mem[10][4:0];
    assign o_per_env    = {r_mem[12], r_mem[11]};
    assign o_env_shape  = r_mem[REG_ENV_SHAPE][3:0];
    assign o_port_a_out = r_mem[REG_IOA];
    assign o_port_b_out = r_mem[REG_IOB];

`ifdef JT49_IOPORT_EN
    // Two-flop synchronisers: the IO pins are asynchronous to the core.
    logic [7:0] r_pa_s1, r_pa_s2, r_pb_s1, r_pb_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pa_s1 <= 8'h00;
            r_pa_s2 <= 8'h00;
            r_pb_s1 <= 8'h00;
            r_pb_s2 <= 8'h00;
        end else begin
            r_pa_s1 <= i_port_a_in;
            r_pa_s2 <= r_pa_s1;
            r_pb_s1 <= i_port_b_in;
            r_pb_s2 <= r_pb_s1;
        end
    end

    // Mixer bit 6/7 = 0 means the port is an input, so reads see the pins.
    always_comb begin
        o_rdat = r_mem[i_raddr] & rd_mask(i_raddr);
        if (i_raddr == REG_IOA && !r_mem[REG_MIXER][6]) begin
            o_rdat = r_pa_s2;
        end else if (i_raddr == REG_IOB && !r_mem[REG_MIXER][7]) begin
            o_rdat = r_pb_s2;
        end
    end
`else
    logic w_unused_ports;
    assign w_unused_ports = ^{i_port_a_in, i_port_b_in};

    always_comb begin
        o_rdat = r_mem[i_raddr] & rd_mask(i_raddr);
    end
`endif

endmodule

// File: rtl/jt49_bus.sv
// Purpose : AY-3-8910 BDIR/BC1 bus responder feeding the jt49 register file.
// Latency : write commits on the edge leaving WRITE; read data/oe one cycle after READ.
// Backpressure: none; every bus cycle is accepted as presented.
// Ports   : clk/rst, host bus (cs_n, bdir, bc1, din, dout, dout_oe), decoded
//           generator fields (per_*, mixer, amp_*, env_*), IO port values.
// Optional: JT49_IOPORT_EN (see jt49_bus_regs) enables IO-pin readback on R14/R15.
module jt49_bus
    import jt49_bus_pkg::*;
#(
    parameter logic [3:0] CHIP_ADDR = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        bdir,
    input  logic        bc1,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        dout_oe,
    output logic [11:0] per_a,
    output logic [11:0] per_b,
    output logic [11:0] per_c,
    output logic [4:0]  per_noise,
    output logic [7:0]  mixer,
    output logic [4:0]  amp_a,
    output logic [4:0]  amp_b,
    output logic [4:0]  amp_c,
    output logic [15:0] per_env,
    output logic [3:0]  env_shape,
    output logic        env_restart,
    output logic [7:0]  port_a_out,
    output logic [7:0]  port_b_out,
    input  logic [7:0]  port_a_in,
    input  logic [7:0]  port_b_in
);

    state_t     r_state, w_next;
    logic [1:0] w_mode;
    logic       w_commit;
    logic       w_latch_hit;
    logic [3:0] r_addr;
    logic       r_sel;
    logic [7:0] r_wdat;
    logic [7:0] r_dout;
    logic       r_dout_oe;
    logic       r_env_restart;
    logic [7:0] w_rdat;

    assign w_mode = cs_n ? MODE_IDLE : {bdir, bc1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // The state simply tracks the bus mode; the write commit fires on the
    // edge that takes the FSM out of WRITE, using the last sampled byte and
    // the address held before any coincident latch updates it.
    always_comb begin
        w_next      = ST_IDLE;
        w_commit    = 1'b0;
        w_latch_hit = 1'b0;
        case (w_mode)
            MODE_READ:  w_next = ST_READ;
            MODE_WRITE: w_next = ST_WRITE;
            MODE_LATCH: w_next = ST_LATCH;
            default:    w_next = ST_IDLE;
        endcase
        if (r_state == ST_WRITE && w_next != ST_WRITE && r_sel) begin
            w_commit = 1'b1;
        end
        if (w_next == ST_LATCH && din[7:4] == CHIP_ADDR) begin
            w_latch_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr        <= 4'd0;
            r_sel         <= 1'b1;
            r_wdat        <= 8'h00;
            r_dout        <= 8'h00;
            r_dout_oe     <= 1'b0;
            r_env_restart <= 1'b0;
        end else begin
            if (w_next == ST_LATCH) begin
                r_sel <= w_latch_hit;
                if (w_latch_hit) r_addr <= din[3:0];
            end
            if (w_next == ST_WRITE) r_wdat <= din;
            r_env_restart <= w_commit && (r_addr == REG_ENV_SHAPE);
            r_dout_oe     <= (r_state == ST_READ);
            r_dout        <= (r_state == ST_READ && r_sel) ? w_rdat : 8'h00;
        end
    end

    assign dout        = r_dout;
    assign dout_oe     = r_dout_oe;
    assign env_restart = r_env_restart;

    jt49_bus_regs u_regs (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_we         (w_commit),
        .i_waddr      (r_addr),
        .i_wdat       (r_wdat),
        .i_raddr      (r_addr),
        .i_port_a_in  (port_a_in),
        .i_port_b_in  (port_b_in),
        .o_rdat       (w_rdat),
        .o_per_a      (per_a),
        .o_per_b      (per_b),
        .o_per_c      (per_c),
        .o_per_noise  (per_noise),
        .o_mixer      (mixer),
        .o_amp_a      (amp_a),
        .o_amp_b      (amp_b),
        .o_amp_c      (amp_c),
        .o_per_env    (per_env),
        .o_env_shape  (env_shape),
        .o_port_a_out (port_a_out),
        .o_port_b_out (port_b_out)
    );

endmodule

// File: tb/tb_jt49_bus.sv
module tb_jt49_bus;

    localparam logic [3:0] CHIP = 4'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_n = 1'b1;
    logic        bdir = 1'b0;
    logic        bc1 = 1'b0;
    logic [7:0]  din = 8'h00;
    logic [7:0]  port_a_in = 8'h00;
    logic [7:0]  port_b_in = 8'h00;
    logic [7:0]  dout;
    logic        dout_oe;
    logic [11:0] per_a, per_b, per_c;
    logic [4:0]  per_noise;
    logic [7:0]  mixer;
    logic [4:0]  amp_a, amp_b, amp_c;
    logic [15:0] per_env;
    logic [3:0]  env_shape;
    logic        env_restart;
    logic [7:0]  port_a_out, port_b_out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: register contents plus the host-visible pointer state.
    logic [7:0] m_regs [16];
    logic [3:0] m_addr;
    logic       m_sel;

    jt49_bus #(.CHIP_ADDR(CHIP)) dut (
        .clk(clk), .rst(rst), .cs_n(cs_n), .bdir(bdir), .bc1(bc1), .din(din),
        .dout(dout), .dout_oe(dout_oe),
        .per_a(per_a), .per_b(per_b), .per_c(per_c), .per_noise(per_noise),
        .mixer(mixer), .amp_a(amp_a), .amp_b(amp_b), .amp_c(amp_c),
        .per_env(per_env), .env_shape(env_shape), .env_restart(env_restart),
        .port_a_out(port_a_out), .port_b_out(port_b_out),
        .port_a_in(port_a_in), .port_b_in(port_b_in)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are read at the next one.
    task automatic step(input logic c, input logic bd, input logic b1, input logic [7:0] d);
        cs_n = c; bdir = bd; bc1 = b1; din = d;
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_addr = 4'd0;
        m_sel  = 1'b1;
    endtask

    function automatic logic [7:0] exp_rd();
        logic [7:0] v;
        if (!m_sel) return 8'h00;
        v = m_regs[m_addr];
        case (m_addr)
            4'd1, 4'd3, 4'd5, 4'd13: return v % 16;
            4'd6, 4'd8, 4'd9, 4'd10: return v % 32;
`ifdef JT49_IOPORT_EN
            4'd14: return (m_regs[7] & 8'h40) != 0 ? v : port_a_in;
            4'd15: return (m_regs[7] & 8'h80) != 0 ? v : port_b_in;
`endif
            default: return v;
        endcase
    endfunction

    task automatic check_fields(input string tag);
        chk({tag, ":per_a"},     per_a,     m_regs[1] % 16 * 256 + m_regs[0]);
        chk({tag, ":per_b"},     per_b,     m_regs[3] % 16 * 256 + m_regs[2]);
        chk({tag, ":per_c"},     per_c,     m_regs[5] % 16 * 256 + m_regs[4]);
        chk({tag, ":per_noise"}, per_noise, m_regs[6] % 32);
        chk({tag, ":mixer"},     mixer,     m_regs[7]);
        chk({tag, ":amp_a"},     amp_a,     m_regs[8] % 32);
        chk({tag, ":amp_b"},     amp_b,     m_regs[9] % 32);
        chk({tag, ":amp_c"},     amp_c,     m_regs[10] % 32);
        chk({tag, ":per_env"},   per_env,   m_regs[12] * 256 + m_regs[11]);
        chk({tag, ":env_shape"}, env_shape, m_regs[13] % 16);
        chk({tag, ":port_a_out"}, port_a_out, m_regs[14]);
        chk({tag, ":port_b_out"}, port_b_out, m_regs[15]);
    endtask

    task automatic do_latch(input logic [7:0] v);
        step(1'b0, 1'b1, 1'b1, v);
        if (v[7:4] == CHIP) begin
            m_addr = v[3:0];
            m_sel  = 1'b1;
        end else begin
            m_sel = 1'b0;
        end
        step(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_write(input logic [7:0] v);
        logic hit;
        step(1'b0, 1'b1, 1'b0, v);
        check_fields("pre_commit");
        step(1'b0, 1'b0, 1'b0, 8'h00);
        hit = m_sel && (m_addr == 4'd13);
        if (m_sel) m_regs[m_addr] = v;
        check_fields("post_commit");
        chk("env_restart_pulse", env_restart, hit);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("env_restart_clear", env_restart, 1'b0);
    endtask

    task automatic do_read();
        logic [7:0] e;
        e = exp_rd();
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("oe_first_cycle", dout_oe, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("oe_in_window", dout_oe, 1'b1);
        chk("dout_in_window", dout, e);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("oe_tail", dout_oe, 1'b1);
        chk("dout_tail", dout, e);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("oe_off", dout_oe, 1'b0);
    endtask

    initial begin
        model_reset();
        port_a_in = 8'hA5;
        port_b_in = 8'h5A;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Reset state
        check_fields("reset");
        chk("reset_dout", dout, 8'h00);
        chk("reset_oe", dout_oe, 1'b0);
        chk("reset_env_restart", env_restart, 1'b0);

        // Tone period A assembly and R1 readback masking
        do_latch(8'h00); do_write(8'h01);
        do_latch(8'h01); do_write(8'h00);
        chk("per_a_001", per_a, 12'h001);
        do_latch(8'h01); do_read();
        do_write(8'hF3); do_read();
        chk("per_a_301", per_a, 12'h301);

        // Envelope shape restarts and envelope period
        do_latch(8'h0D); do_write(8'h0E); do_write(8'h0E);
        chk("env_shape_E", env_shape, 4'hE);
        do_latch(8'h0B); do_write(8'h0A);
        do_latch(8'h0C); do_write(8'h00);
        chk("per_env_000A", per_env, 16'h000A);

        // Foreign chip address deselects this chip
        do_latch(8'h17); do_write(8'h55); do_read();
        do_latch(8'h07); do_read();

        // Amplitude mask on R8
        do_latch(8'h08); do_write(8'hFF); do_read();
        chk("amp_a_1F", amp_a, 5'h1F);

        // cs_n going high mid-write commits on that edge
        do_latch(8'h00);
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        chk("cs_pre_commit", per_a[7:0], 8'h01);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        m_regs[0] = 8'hAA;
        chk("cs_commit", per_a[7:0], 8'hAA);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_fields("cs_after");

        // IO port readback
        do_latch(8'h0E); do_write(8'h12);
        do_latch(8'h07); do_write(8'h3F);
        do_latch(8'h0E); do_read();
        do_latch(8'h07); do_write(8'h7F);
        do_latch(8'h0E); do_read();

        // Randomised transactions against the model
        for (int it = 0; it < 60; it++) begin
            int op;
            logic [7:0] b;
            op = int'($urandom_range(0, 3));
            b  = 8'($urandom);
            case (op)
                0: begin
                    if ($urandom_range(0, 3) != 0) b[7:4] = CHIP;
                    do_latch(b);
                end
                1: do_write(b);
                2: do_read();
                default: begin
                    port_a_in = 8'($urandom);
                    port_b_in = 8'($urandom);
                    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
                end
            endcase
        end

        // Reset during a pending write: no commit, everything cleared
        do_latch(8'h00); do_write(8'h22);
        chk("r0_22", per_a[7:0], 8'h22);
        do_latch(8'h0D);
        step(1'b0, 1'b1, 1'b0, 8'h55);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        model_reset();
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check_fields("after_reset");
        chk("rst_oe", dout_oe, 1'b0);
        chk("rst_env_restart", env_restart, 1'b0);
        chk("rst_dout", dout, 8'h00);
        do_read();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
